// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked ripple adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of chunks an operand is split into.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk counter width: clog2 of the chunk count, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunked_adder_if.sv
// Operand/result bus of the chunked adder.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds valid and its data stable until the
// transfer; the consumer may raise or drop ready at any time. in_* carries
// operands (master -> slave), out_* carries the result (slave -> master).
interface chunked_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple of full adders. carry_msb_in_o is the carry
// entering the top bit, used by the parent to derive signed overflow.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             carry_in_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             carry_out_o,
  output logic             carry_msb_in_o
);

  logic [CHUNK:0] c;

  // Ripple the carry bit by bit through CHUNK full adders.
  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = carry_in_i;
    for (int i = 0; i < CHUNK; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign carry_out_o    = c[CHUNK];
  assign carry_msb_in_o = c[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle ripple adder: adds two WIDTH-bit operands CHUNK bits per clock,
// carrying between chunks in a register. Optional macro ADDER_SUB_EN enables
// subtraction (a - b) selected by the sub input at acceptance.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            reset,
  chunked_adder_if.slave  bus,
  output state_t          state_o
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = cnt_w(NCHUNK);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("chunked_adder: WIDTH must be >= 1 and a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;

  logic [CHUNK-1:0] ch_a, ch_b, ch_sum;
  logic             ch_co, ch_msb;
  logic             last_chunk;

  assign ch_a       = a_q[cnt_q * CHUNK +: CHUNK];
  assign ch_b       = b_q[cnt_q * CHUNK +: CHUNK];
  assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i            (ch_a),
    .b_i            (ch_b),
    .carry_in_i     (carry_q),
    .sum_o          (ch_sum),
    .carry_out_o    (ch_co),
    .carry_msb_in_o (ch_msb)
  );

`ifndef ADDER_SUB_EN
  // Without subtraction support the sub request is intentionally ignored.
  logic unused_sub;
  assign unused_sub = bus.sub;
`endif

  // Next-state logic: accept operands, add one chunk per RUN cycle, hold result.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.carry_in;
`ifdef ADDER_SUB_EN
          // a - b as a + ~b + 1; carry_out then reads as "no borrow".
          if (bus.sub) begin
            b_d     = ~bus.b;
            carry_d = 1'b1;
          end
`endif
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[cnt_q * CHUNK +: CHUNK] = ch_sum;
        carry_d = ch_co;
        cnt_d   = cnt_q + 1'b1;
        if (last_chunk) begin
          co_d    = ch_co;
          ov_d    = ch_msb ^ ch_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ov_q;
  assign state_o       = state_q;

endmodule
